cache_arbiter: RTL

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported cache.
// One transaction at a time: Idle -> Settle -> Check -> (Miss -> Settle -> Check)* -> Commit.
module cache_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic [31:0] i_data,
  output logic        i_done,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  input  logic [3:0]  d_write_enable,
  output logic [31:0] d_data,
  output logic        d_done,
  output logic        enable,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic [3:0]  write_enable,
  input  logic [31:0] data_out,
  input  logic        busy,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    MISS   = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // last_d names the most recent grant; outside Idle it is also the current owner.
  logic last_d;
  logic missed;
  logic i_elig;
  logic d_elig;
  logic grant;
  logic pick_d;

  // Handshake: a port is picked up when req=1 and its done is low; it must hold
  // req/address/data/mask until its done pulse, which lasts exactly one cycle.
  assign i_elig = i_req & ~i_done;
  assign d_elig = d_req & ~d_done;
  assign grant  = i_elig | d_elig;
  assign pick_d = d_elig & (~i_elig | ~last_d);

  always_comb begin
    state_next   = state;
    enable       = 1'b0;
    address      = 32'h0;
    data_in      = 32'h0;
    write_enable = 4'h0;
    if (state != IDLE) begin
      enable  = 1'b1;
      address = last_d ? d_address : i_address;
      data_in = last_d ? d_data_in : 32'h0;
    end
    case (state)
      IDLE: begin
        if (grant) state_next = SETTLE;
      end
      SETTLE: state_next = CHECK;
      CHECK: begin
        state_next = busy ? MISS : COMMIT;
      end
      MISS: begin
        // Re-run the lookup after the burst so the write sees fresh tag state.
        if (!busy) state_next = SETTLE;
      end
      COMMIT: begin
        write_enable = last_d ? d_write_enable : 4'h0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      missed      <= 1'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_data      <= 32'h0;
      d_data      <= 32'h0;
      stat_hits   <= 32'h0;
      stat_misses <= 32'h0;
    end else begin
      state  <= state_next;
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (state == IDLE && grant) last_d <= pick_d;
      if (state == CHECK && busy) missed <= 1'b1;
      if (state == COMMIT) begin
        missed <= 1'b0;
        if (missed) stat_misses <= stat_misses + 32'd1;
        else        stat_hits   <= stat_hits + 32'd1;
        if (last_d) begin
          d_done <= 1'b1;
          if (d_write_enable == 4'h0) d_data <= data_out;
        end else begin
          i_done <= 1'b1;
          i_data <= data_out;
        end
      end
    end
  end

endmodule
